// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared state encoding, bus widths and {x,y} address packing
package sram_arb_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_SET  = 3'd1,
    ST_WR_STB  = 3'd2,
    ST_CLR_SET = 3'd3,
    ST_CLR_STB = 3'd4
  } arb_state_t;

  function automatic logic [ADDR_W-1:0] pack_xy(input logic [9:0] x, input logic [9:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/sram_wr_fifo.sv
// rtl/sram_wr_fifo.sv - pixel write queue; head is visible combinationally on rdata
module sram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (PW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sram_frame_arbiter.sv
// rtl/sram_frame_arbiter.sv - shares the frame-buffer SRAM between display scan, queued pixel writes and clear
module sram_frame_arbiter
  import sram_arb_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] CLEAR_DATA  = 16'hFFFF,
  parameter int          CLEAR_WORDS = 2**20
) (
  input  logic                          VGA_CTRL_CLK,
  input  logic                          reset_n,
  input  logic [11:0]                   current_X,
  input  logic [11:0]                   current_Y,
  input  logic                          VGA_VS,
  input  logic                          VGA_HS,
  input  logic                          clear_req,
  output logic                          clear_busy,
  output logic                          clear_done,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DATA_W-1:0]             pix_data,
  inout  wire  [DATA_W-1:0]             SRAM_DQ,
  output logic [ADDR_W-1:0]             SRAM_ADDR,
  output logic                          SRAM_WE_N,
  output logic                          SRAM_CE_N,
  output logic                          SRAM_OE_N,
  output logic                          SRAM_UB_N,
  output logic                          SRAM_LB_N
);

  localparam logic [20:0] CLR_LAST = 21'(CLEAR_WORDS - 1);

  arb_state_t                 state, state_nxt;
  logic [20:0]                clr_cnt, cnt_nxt;
  logic [DATA_W-1:0]          data_reg, data_nxt;
  logic [ADDR_W-1:0]          addr_nxt;
  logic                       we_n_nxt;
  logic                       done_nxt;
  logic                       blank;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_pop;
  logic [ADDR_W+DATA_W-1:0]   fifo_head;
  logic                       unused_xy;

  assign blank      = ~VGA_VS | ~VGA_HS;
  assign clear_busy = (state == ST_CLR_SET) || (state == ST_CLR_STB);
  assign wr_ready   = !fifo_full && !clear_busy;
  assign fifo_pop   = (state == ST_WR_STB);
  assign unused_xy  = ^{current_X[11:10], current_Y[11:10]};

  assign SRAM_DQ   = SRAM_WE_N ? {DATA_W{1'bz}} : data_reg;
  assign pix_data  = SRAM_WE_N ? SRAM_DQ : '0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  sram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (VGA_CTRL_CLK),
    .rst_n (reset_n),
    .push  (wr_valid && wr_ready),
    .wdata ({wr_addr, wr_data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = clr_cnt;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clear_req) begin
          state_nxt = ST_CLR_SET;
          cnt_nxt   = '0;
        end else if (blank && !fifo_empty) begin
          state_nxt = ST_WR_SET;
        end
      end
      ST_WR_SET:  state_nxt = blank ? ST_WR_STB : ST_IDLE;
      ST_WR_STB:  state_nxt = ST_IDLE;
      ST_CLR_SET: state_nxt = ST_CLR_STB;
      ST_CLR_STB: begin
        if (clr_cnt == CLR_LAST) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt   = clr_cnt + 21'd1;
          state_nxt = ST_CLR_SET;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus registers are loaded for the state being entered so they line up with it.
  always_comb begin
    addr_nxt = SRAM_ADDR;
    data_nxt = data_reg;
    we_n_nxt = 1'b1;
    case (state_nxt)
      ST_IDLE:    addr_nxt = pack_xy(current_X[9:0], current_Y[9:0]);
      ST_WR_SET: begin
        addr_nxt = fifo_head[ADDR_W+DATA_W-1:DATA_W];
        data_nxt = fifo_head[DATA_W-1:0];
      end
      ST_CLR_SET: begin
        addr_nxt = cnt_nxt[ADDR_W-1:0];
        data_nxt = CLEAR_DATA;
      end
      ST_WR_STB, ST_CLR_STB: we_n_nxt = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge VGA_CTRL_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      clr_cnt    <= '0;
      data_reg   <= '0;
      SRAM_ADDR  <= '0;
      SRAM_WE_N  <= 1'b1;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= cnt_nxt;
      data_reg   <= data_nxt;
      SRAM_ADDR  <= addr_nxt;
      SRAM_WE_N  <= we_n_nxt;
      clear_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// tb/tb_sram_frame_arbiter.sv - directed bench for sram_frame_arbiter
module tb_sram_frame_arbiter;

  logic        clk;
  logic        reset_n;
  logic [11:0] cur_x, cur_y;
  logic        vs, hs;
  logic        clear_req;
  logic        clear_busy, clear_done;
  logic        wr_valid, wr_ready;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  fifo_level;
  logic [15:0] pix_data;
  wire  [15:0] sram_dq;
  logic [19:0] sram_addr;
  logic        we_n, ce_n, oe_n, ub_n, lb_n;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int c0;
  bit accepted;

  logic [19:0] log_addr[$];
  logic [15:0] log_data[$];
  int          log_cyc[$];
  int          done_cyc[$];

  sram_frame_arbiter #(
    .FIFO_DEPTH  (4),
    .CLEAR_DATA  (16'hFFFF),
    .CLEAR_WORDS (8)
  ) dut (
    .VGA_CTRL_CLK (clk),
    .reset_n      (reset_n),
    .current_X    (cur_x),
    .current_Y    (cur_y),
    .VGA_VS       (vs),
    .VGA_HS       (hs),
    .clear_req    (clear_req),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .fifo_level   (fifo_level),
    .pix_data     (pix_data),
    .SRAM_DQ      (sram_dq),
    .SRAM_ADDR    (sram_addr),
    .SRAM_WE_N    (we_n),
    .SRAM_CE_N    (ce_n),
    .SRAM_OE_N    (oe_n),
    .SRAM_UB_N    (ub_n),
    .SRAM_LB_N    (lb_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n === 1'b1 && we_n === 1'b0) begin
      log_addr.push_back(sram_addr);
      log_data.push_back(sram_dq);
      log_cyc.push_back(cyc);
    end
    if (clear_done === 1'b1) done_cyc.push_back(cyc);
  end

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); log_cyc.delete(); done_cyc.delete();
  endtask

  task automatic push_word(input logic [19:0] a, input logic [15:0] d);
    wr_addr = a; wr_data = d; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cur_x = 12'($urandom); cur_y = 12'($urandom);
      vs = 1'($urandom); hs = 1'($urandom); clear_req = 1'($urandom);
      wr_valid = 1'($urandom); wr_addr = 20'($urandom); wr_data = 16'($urandom);
      @(negedge clk);
      vectors++;
      if (we_n !== 1'b1 || wr_ready !== 1'b1 || fifo_level !== 3'd0 || clear_busy !== 1'b0 ||
          clear_done !== 1'b0 || sram_addr !== 20'h0) begin
        miscompares++;
        $display("FAIL reset: we_n=%b ready=%b level=%0d busy=%b done=%b addr=%h, required 1 1 0 0 0 00000",
                 we_n, wr_ready, fifo_level, clear_busy, clear_done, sram_addr);
      end
    end
    vectors++;
    if ({ce_n, oe_n, ub_n, lb_n} !== 4'b0000) begin
      miscompares++;
      $display("FAIL tie_offs: got %b required 0000", {ce_n, oe_n, ub_n, lb_n});
    end
    clear_req = 1'b0; wr_valid = 1'b0; vs = 1'b1; hs = 1'b1; cur_x = '0; cur_y = '0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_blank_write();
    clear_logs();
    push_word(20'h0A0C8, 16'h1234);
    vectors++;
    if (fifo_level !== 3'd1) begin
      miscompares++; $display("FAIL bw_level_push: got %0d required 1", fifo_level);
    end
    vs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (we_n !== 1'b0 || sram_addr !== 20'h0A0C8 || sram_dq !== 16'h1234 || pix_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL bw_strobe: we_n=%b addr=%h dq=%h pix=%h, required 0 0a0c8 1234 0000",
               we_n, sram_addr, sram_dq, pix_data);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (log_addr.size() != 1 || fifo_level !== 3'd0) begin
      miscompares++;
      $display("FAIL bw_single: strobes=%0d level=%0d, required 1 0", log_addr.size(), fifo_level);
    end
    vs = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_deferred();
    clear_logs();
    push_word(20'h12345, 16'hBEEF);
    for (int i = 0; i < 100; i++) begin
      cur_x = 12'(i * 3); cur_y = 12'(i + 7);
      @(negedge clk);
      vectors++;
      if (sram_addr !== {cur_x[9:0], cur_y[9:0]} || we_n !== 1'b1) begin
        miscompares++;
        $display("FAIL df_track[%0d]: addr=%h we_n=%b, required %h 1", i, sram_addr, we_n,
                 {cur_x[9:0], cur_y[9:0]});
      end
    end
    vectors++;
    if (fifo_level !== 3'd1 || log_addr.size() != 0) begin
      miscompares++;
      $display("FAIL df_held: level=%0d strobes=%0d, required 1 0", fifo_level, log_addr.size());
    end
    hs = 1'b0; c0 = cyc;
    repeat (5) @(negedge clk);
    vectors++;
    if (log_addr.size() != 1) begin
      miscompares++; $display("FAIL df_count: got %0d required 1", log_addr.size());
    end else if (log_addr[0] !== 20'h12345 || log_data[0] !== 16'hBEEF || log_cyc[0] != c0 + 2) begin
      miscompares++;
      $display("FAIL df_write: addr=%h data=%h cyc=%0d, required 12345 beef %0d",
               log_addr[0], log_data[0], log_cyc[0], c0 + 2);
    end
    hs = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    clear_logs();
    for (int k = 0; k < 4; k++) push_word(20'h00100 + 20'(k), 16'hA000 + 16'(k));
    vectors++;
    if (wr_ready !== 1'b0 || fifo_level !== 3'd4) begin
      miscompares++;
      $display("FAIL bp_full: ready=%b level=%0d, required 0 4", wr_ready, fifo_level);
    end
    wr_addr = 20'h00104; wr_data = 16'hA004; wr_valid = 1'b1;
    vs = 1'b0;
    accepted = 1'b0;
    for (int t = 0; t < 50 && !accepted; t++) begin
      @(negedge clk);
      if (wr_ready === 1'b1) begin
        accepted = 1'b1;
        vectors++;
        if (log_addr.size() != 1) begin
          miscompares++;
          $display("FAIL bp_accept_after_pop: strobes=%0d required 1", log_addr.size());
        end
        @(negedge clk);
      end
    end
    wr_valid = 1'b0;
    vectors++;
    if (!accepted) begin
      miscompares++; $display("FAIL bp_timeout: ready=0 required 1 within 50 cycles");
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (log_addr.size() != 5 || fifo_level !== 3'd0) begin
      miscompares++;
      $display("FAIL bp_count: strobes=%0d level=%0d, required 5 0", log_addr.size(), fifo_level);
    end
    for (int k = 0; k < 5; k++) begin
      if (k < log_addr.size()) begin
        vectors++;
        if (log_addr[k] !== 20'h00100 + 20'(k) || log_data[k] !== 16'hA000 + 16'(k)) begin
          miscompares++;
          $display("FAIL bp_order[%0d]: addr=%h data=%h, required %h %h", k, log_addr[k], log_data[k],
                   20'h00100 + 20'(k), 16'hA000 + 16'(k));
        end
      end
    end
    vs = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_blank_edge();
    clear_logs();
    push_word(20'h3FF00, 16'h5A5A);
    hs = 1'b0;
    @(negedge clk);
    hs = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (log_addr.size() != 0 || fifo_level !== 3'd1) begin
      miscompares++;
      $display("FAIL be_abort: strobes=%0d level=%0d, required 0 1", log_addr.size(), fifo_level);
    end
    hs = 1'b0;
    repeat (4) @(negedge clk);
    hs = 1'b1;
    vectors++;
    if (log_addr.size() != 1 || fifo_level !== 3'd0) begin
      miscompares++;
      $display("FAIL be_retry_count: strobes=%0d level=%0d, required 1 0", log_addr.size(), fifo_level);
    end else if (log_addr[0] !== 20'h3FF00 || log_data[0] !== 16'h5A5A) begin
      miscompares++;
      $display("FAIL be_retry: addr=%h data=%h, required 3ff00 5a5a", log_addr[0], log_data[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_clear();
    clear_logs();
    push_word(20'h00ABC, 16'h0001);
    push_word(20'h00DEF, 16'h0002);
    clear_req = 1'b1; vs = 1'b0; c0 = cyc;
    @(negedge clk);
    clear_req = 1'b0;
    vectors++;
    if (clear_busy !== 1'b1 || wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_busy: busy=%b ready=%b, required 1 0", clear_busy, wr_ready);
    end
    repeat (30) @(negedge clk);
    vectors++;
    if (log_addr.size() != 10 || clear_busy !== 1'b0 || fifo_level !== 3'd0) begin
      miscompares++;
      $display("FAIL clr_count: strobes=%0d busy=%b level=%0d, required 10 0 0",
               log_addr.size(), clear_busy, fifo_level);
    end
    for (int i = 0; i < 8; i++) begin
      if (i < log_addr.size()) begin
        vectors++;
        if (log_addr[i] !== 20'(i) || log_data[i] !== 16'hFFFF || log_cyc[i] != c0 + 2 + 2 * i) begin
          miscompares++;
          $display("FAIL clr_word[%0d]: addr=%h data=%h cyc=%0d, required %h ffff %0d",
                   i, log_addr[i], log_data[i], log_cyc[i], 20'(i), c0 + 2 + 2 * i);
        end
      end
    end
    vectors++;
    if (done_cyc.size() != 1) begin
      miscompares++; $display("FAIL clr_done_count: got %0d required 1", done_cyc.size());
    end else if (done_cyc[0] != c0 + 17) begin
      miscompares++; $display("FAIL clr_done_time: got %0d required %0d", done_cyc[0], c0 + 17);
    end
    if (log_addr.size() == 10) begin
      vectors++;
      if (log_addr[8] !== 20'h00ABC || log_data[8] !== 16'h0001 || log_cyc[8] != c0 + 19 ||
          log_addr[9] !== 20'h00DEF || log_data[9] !== 16'h0002 || log_cyc[9] != c0 + 22) begin
        miscompares++;
        $display("FAIL clr_drain: %h/%h@%0d %h/%h@%0d, required 00abc/0001@%0d 00def/0002@%0d",
                 log_addr[8], log_data[8], log_cyc[8], log_addr[9], log_data[9], log_cyc[9],
                 c0 + 19, c0 + 22);
      end
    end
    vs = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_strobe();
    push_word(20'h00777, 16'h7777);
    vs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (we_n !== 1'b0) begin
      miscompares++; $display("FAIL rs_strobe: we_n=%b required 0", we_n);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (we_n !== 1'b1 || fifo_level !== 3'd0 || wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rs_async: we_n=%b level=%0d ready=%b, required 1 0 1", we_n, fifo_level, wr_ready);
    end
    @(negedge clk);
    vs = 1'b1; reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_blank_write();
    test_deferred();
    test_backpressure();
    test_blank_edge();
    test_clear();
    test_reset_mid_strobe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
